// File: rtl/dut_rr_arbiter.sv
// Round-robin arbiter that multiplexes N valid/ready requesters onto the single-bit dut input.
// Define DUT_RR_ARB_STATS_EN to add the o_beat_count accepted-beat counter port.
module dut_rr_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req_valid,
  input  logic [N-1:0]     i_req_data,
  output logic [N-1:0]     o_req_ready,
  output logic [N-1:0]     o_grant,
  output logic             o_busy,
  output logic             o_valid,
`ifdef DUT_RR_ARB_STATS_EN
  output logic [CNT_W-1:0] o_beat_count,
`endif
  output logic             o_data
);

  localparam int PTR_W   = (N > 1) ? $clog2(N) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  if (N < 2 || MAX_BURST < 1 || CNT_W < 1) begin : g_bad_params
    $error("dut_rr_arbiter: illegal parameter values");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [PTR_W-1:0]   owner, owner_nxt;
  logic [PTR_W-1:0]   pick;
  logic [BURST_W-1:0] burst, burst_nxt;
  logic [N-1:0]       grant_nxt;
  logic               busy_nxt, valid_nxt, data_nxt;
  logic               any_req, xfer, last_beat, release_now;

  assign o_req_ready = o_grant;
  assign any_req     = |i_req_valid;
  // o_grant is one-hot while granted and zero when idle, so masking selects the owner.
  assign xfer        = |(i_req_valid & o_grant);
  assign last_beat   = (burst == BURST_W'(MAX_BURST - 1));
  assign release_now = (state == GRANT) && (!xfer || last_beat);

  // First requesting index at or after ptr, wrapping around.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      burst   <= '0;
      o_grant <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      burst   <= burst_nxt;
      o_grant <= grant_nxt;
      o_busy  <= busy_nxt;
      o_valid <= valid_nxt;
      o_data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt   = ptr;
    owner_nxt = owner;
    burst_nxt = burst;
    grant_nxt = o_grant;
    busy_nxt  = o_busy;
    valid_nxt = 1'b0;
    data_nxt  = o_data;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = pick;
          grant_nxt = {{(N-1){1'b0}}, 1'b1} << pick;
          busy_nxt  = 1'b1;
          burst_nxt = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          valid_nxt = 1'b1;
          data_nxt  = |(i_req_data & o_grant);
          burst_nxt = burst + 1'b1;
        end
        // The final beat of a full burst still emits its strobe on the releasing edge.
        if (release_now) begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = (owner == PTR_W'(N - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef DUT_RR_ARB_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_beat_count <= '0;
    else if (xfer) o_beat_count <= o_beat_count + 1'b1;
  end
`endif

endmodule

// File: doc/dut_rr_arbiter.md
Name: dut_rr_arbiter

Overview:
- Round-robin arbiter that shares the single-bit valid/data input of the dut register stage between N requesters.
- Each requester uses a valid/ready handshake. The arbiter drives the dut's i_valid/i_data from registered outputs.
- A grant holds for a bounded burst, so one requester cannot starve the others.
- Sits directly in front of dut; o_valid → dut.i_valid, o_data → dut.i_data, shared i_clk/i_rst.

Parameters:
- N, 4, number of requesters; legal ≥2.
- MAX_BURST, 4, maximum consecutive beats per grant; legal ≥1.
- CNT_W, 16, width of beat counter (optional feature only).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req_valid  input  N  per-requester valid.
- i_req_data  input  N  per-requester data bit.
- o_req_ready  output  N  per-requester ready; equals o_grant.
- o_grant  output  N  one-hot current owner, or all-zero when idle; registered.
- o_busy  output  1  1 while in GRANT state; registered.
- o_valid  output  1  to dut i_valid; registered single-cycle beat strobe.
- o_data  output  1  to dut i_data; registered.
- o_beat_count  output  CNT_W  total accepted beats (DUT_RR_ARB_STATS_EN only).

Behaviour:
- Reset (async assert, any time): state=IDLE, ptr=0, burst=0, o_grant=0, o_busy=0, o_valid=0, o_data=0, o_beat_count=0. Nothing is emitted after reset deasserts until a new arbitration.
- ptr: $clog2(N)-bit round-robin start index. burst: counter 0..MAX_BURST.
- IDLE:
  - If any i_req_valid bit is set, select the first index k searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Next edge: o_grant=1<<k, o_busy=1, burst=0, state=GRANT.
  - No beat is transferred in the IDLE cycle (1-cycle arbitration bubble).
- GRANT (owner k):
  - Transfer when i_req_valid[k] && o_req_ready[k]. On transfer: next edge o_valid=1, o_data=i_req_data[k], burst+1.
  - On a non-transfer cycle: o_valid=0 next edge; o_data holds its last value.
  - Release when either holds:
    - (a) i_req_valid[k]=0 in a GRANT cycle, with no transfer that cycle;
    - (b) a transfer makes burst reach MAX_BURST.
  - On release, next edge: o_grant=0, o_busy=0, ptr=(k+1) mod N (wraps N-1→0), state=IDLE.
  - In case (b), the final beat's o_valid=1 is emitted on the same edge.
- Non-owner i_req_valid is ignored during GRANT; o_req_ready is 0 for non-owners.
- Latency:
  - Accepted beat → o_valid/o_data: 1 cycle.
  - Accepted beat → dut o_data: 2 cycles.
  - Request from idle → first accept: 1 cycle.
- MAX_BURST=1: every grant is exactly one beat followed by an IDLE cycle.
- o_grant is always one-hot or zero; o_valid=1 only on the cycle after an accepted transfer.

Optional Feature:
- Macro DUT_RR_ARB_STATS_EN.
- Defined:
  - o_beat_count port exists.
  - Increments by 1 on every accepted transfer and wraps modulo 2^CNT_W.
  - Cleared only by i_rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: i_rst pulse, all i_req_valid=0 for 10 cycles → o_grant=0, o_valid=0, o_data=0, o_busy=0 throughout.
- Single requester burst: N=4, MAX_BURST=4, req1 valid with data 1,0,1,1,1 held for 5 beats →
  - grant=4'b0010 one cycle after request;
  - o_valid high 4 consecutive cycles with o_data 1,0,1,1;
  - release, 1 idle cycle, re-grant to req1, fifth beat 1;
  - dut o_data follows two cycles after each accept.
- Fairness and wrap: all 4 requesters valid continuously →
  - grant order 0,1,2,3,0;
  - each grant carries exactly 4 beats;
  - one bubble cycle between grants;
  - ptr wraps 3→0.
- Early release: req2 granted, drops valid after 2 beats → exactly 2 o_valid pulses, ptr=3, a pending req3 is granted next.
- Reset mid-burst: assert i_rst asynchronously during beat 2 of a grant → o_grant, o_valid, o_busy go to 0 immediately (before next edge); after release, arbitration restarts from ptr=0.
- Stats (DUT_RR_ARB_STATS_EN, CNT_W=4): 17 accepted beats → o_beat_count=1 (wrapped); rebuild without macro → port absent, identical waveform on all other outputs.
